data_rom_wbuf: RTL

//  Data-memory responder for the control unit's store signal: accepts stores (data_rom_write_en

---
 rtl/data_rom_wbuf.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/data_rom_wbuf.sv
// Data-memory responder: posted in-order store buffer in front of a single-port synchronous RAM.
// Latency: loads return rd_data/rd_valid one cycle after acceptance; stores retire to RAM in idle read cycles.
// Backpressure: stall asserts while the buffer is full; requests are ignored then and must be held.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   data_rom_write_en,       store request with word address and data
//   wr_addr, wr_data
//   rd_en, rd_addr           load request with word address
//   rd_data, rd_valid        registered load result and its one-cycle valid strobe
//   stall                    buffer full; hold all requests
//   wbuf_count               number of stores currently buffered
//
// WBUF_DEPTH must be a power of two (>=2) so the pointers wrap naturally.

module data_rom_wbuf #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            data_rom_write_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            rd_en,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [DATA_W-1:0]               rd_data,
  output logic                            rd_valid,
  output logic                            stall,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_count
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  // Write-buffer storage (no reset needed: validity comes from count_q)
  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Backing RAM and its registered read port
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_dout_q;

  // Load result path: either forwarded buffer data or the RAM output register
  logic              rd_valid_q;
  logic              fwd_sel_q;
  logic [DATA_W-1:0] fwd_dat_q;

  logic              load_acc;
  logic              store_acc;
  logic              drain;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_dat;
  logic [PTR_W-1:0]  fwd_idx;

  assign stall     = (count_q == CNT_W'(WBUF_DEPTH));
  assign load_acc  = rd_en && !stall;
  assign store_acc = data_rom_write_en && !stall;
  // A full buffer blocks loads, so drain always gets the port then.
  assign drain     = !load_acc && (count_q != '0);

  // Scan oldest to youngest; a later hit overrides, leaving the youngest match.
  // Only entries present at the start of the cycle are scanned, so a store
  // accepted alongside this load is not visible to it.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    fwd_idx = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_addr_q[fwd_idx] == rd_addr)) begin
        fwd_hit = 1'b1;
        fwd_dat = wb_data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d = head_q + PTR_W'(1);
    end
    if (store_acc) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({store_acc, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      // Selecting the zeroed forward register gives rd_data=0 without touching RAM.
      fwd_sel_q  <= 1'b1;
      fwd_dat_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_valid_q <= load_acc;
      if (load_acc) begin
        fwd_sel_q <= fwd_hit;
        fwd_dat_q <= fwd_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_acc) begin
      wb_addr_q[tail_q] <= wr_addr;
      wb_data_q[tail_q] <= wr_data;
    end
  end

  // Single-port RAM: arbitration guarantees at most one of read/write per cycle.
  // Writes are suppressed during reset so discarded stores never reach memory.
  always_ff @(posedge clk) begin
    if (rst_n && drain) begin
      mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
    end
    if (rst_n && load_acc) begin
      ram_dout_q <= mem_q[rd_addr];
    end
  end

  assign rd_data    = fwd_sel_q ? fwd_dat_q : ram_dout_q;
  assign rd_valid   = rd_valid_q;
  assign wbuf_count = count_q;

endmodule
